// File: rtl/video_pkg.sv
// Shared video timing and colour constants for the overlay path.
package video_pkg;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    localparam logic [7:0] BOX_R = 8'd255;
    localparam logic [7:0] BOX_G = 8'd127;
    localparam logic [7:0] BOX_B = 8'd0;
    localparam logic [7:0] BG_R  = 8'd80;
    localparam logic [7:0] BG_G  = 8'd80;
    localparam logic [7:0] BG_B  = 8'd80;
endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one raw push button.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
        end
    end

    // Count only while a level change is pending; any bounce back restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (sync_q2 == dout) begin
            cnt <= '0;
        end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            cnt  <= '0;
            dout <= sync_q2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/box_controller.sv
// Box overlay controller: debounced buttons move the box once per frame,
// and each pixel is coloured box / background / black with one cycle latency.
module box_controller
    import video_pkg::*;
#(
    parameter int unsigned BOX_W      = 100,
    parameter int unsigned BOX_H      = 100,
    parameter int unsigned INIT_X     = 100,
    parameter int unsigned INIT_Y     = 100,
    parameter int unsigned STEP       = 1,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       blanking,
    input  logic       v_sync,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic       frame_tick
);
    localparam logic signed [10:0] MAX_X  = 11'(H_ACTIVE - BOX_W);
    localparam logic signed [10:0] MAX_Y  = 11'(V_ACTIVE - BOX_H);
    localparam logic signed [10:0] STEP_S = 11'(STEP);

    if (INIT_X > H_ACTIVE - BOX_W || INIT_Y > V_ACTIVE - BOX_H) begin : g_bad_init
        $error("box_controller: initial box position lies outside the active area");
    end

    logic deb_right, deb_left, deb_up, deb_down;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (.clk(clk), .rst(rst), .din(btn_right), .dout(deb_right));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left  (.clk(clk), .rst(rst), .din(btn_left),  .dout(deb_left));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up    (.clk(clk), .rst(rst), .din(btn_up),    .dout(deb_up));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down  (.clk(clk), .rst(rst), .din(btn_down),  .dout(deb_down));

    // v_sync already lives in this clock domain, so a single delay suffices.
    logic v_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_sync_q   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            v_sync_q   <= v_sync;
            frame_tick <= v_sync & ~v_sync_q;
        end
    end

    // Next position: one prioritised move, signed so underflow is visible before clamping.
    logic signed [10:0] nx;
    logic signed [10:0] ny;
    logic [9:0]         box_x_nxt;
    logic [9:0]         box_y_nxt;

    always_comb begin
        nx = $signed({1'b0, box_x});
        ny = $signed({1'b0, box_y});
        if (deb_right)      nx = nx + STEP_S;
        else if (deb_left)  nx = nx - STEP_S;
        else if (deb_up)    ny = ny - STEP_S;
        else if (deb_down)  ny = ny + STEP_S;

        if (nx < 11'sd0)      box_x_nxt = '0;
        else if (nx > MAX_X)  box_x_nxt = 10'(MAX_X);
        else                  box_x_nxt = 10'(nx);

        if (ny < 11'sd0)      box_y_nxt = '0;
        else if (ny > MAX_Y)  box_y_nxt = 10'(MAX_Y);
        else                  box_y_nxt = 10'(ny);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            box_x <= 10'(INIT_X);
            box_y <= 10'(INIT_Y);
        end else if (frame_tick) begin
            box_x <= box_x_nxt;
            box_y <= box_y_nxt;
        end
    end

    // Compares widened to 11 bits so box edge + size never wraps.
    logic [10:0] x_w, y_w, bx_w, by_w;
    logic        inside_c;

    always_comb begin
        x_w      = {1'b0, x};
        y_w      = {1'b0, y};
        bx_w     = {1'b0, box_x};
        by_w     = {1'b0, box_y};
        inside_c = (x_w >= bx_w) && (x_w < bx_w + 11'(BOX_W)) &&
                   (y_w >= by_w) && (y_w < by_w + 11'(BOX_H));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (blanking) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (inside_c) begin
            red   <= BOX_R;
            green <= BOX_G;
            blue  <= BOX_B;
        end else begin
            red   <= BG_R;
            green <= BG_G;
            blue  <= BG_B;
        end
    end
endmodule

// File: tb/tb_box_controller.sv
// Scoreboard bench for box_controller: pixel colours queued on drive and
// compared one cycle later; box position checked against a bench-side model.
module tb_box_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic       btn_right, btn_left, btn_up, btn_down;
    logic [9:0] x, y;
    logic       blanking, v_sync;
    logic [7:0] red, green, blue;
    logic [9:0] box_x, box_y;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int mx = 100;
    int my = 100;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    box_controller dut (
        .clk(clk), .rst(rst),
        .btn_right(btn_right), .btn_left(btn_left), .btn_up(btn_up), .btn_down(btn_down),
        .x(x), .y(y), .blanking(blanking), .v_sync(v_sync),
        .red(red), .green(green), .blue(blue),
        .box_x(box_x), .box_y(box_y), .frame_tick(frame_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [23:0] model_rgb(input int px, input int py, input bit blank,
                                              input int bx, input int by);
        if (blank) return 24'h000000;
        if (px >= bx && px < bx + 100 && py >= by && py < by + 100) return 24'hFF7F00;
        return 24'h505050;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drive one pixel, queue its expected colour, compare after the pipeline stage.
    task automatic pixel(input string tag, input int px, input int py, input bit blank);
        logic [23:0] e;
        x = 10'(px);
        y = 10'(py);
        blanking = blank;
        exp_q.push_back(model_rgb(px, py, blank, mx, my));
        step();
        e = exp_q.pop_front();
        check(tag, {red, green, blue}, e);
        blanking = 1'b1;
    endtask

    // One v_sync pulse; returns the number of frame_tick cycles observed.
    task automatic frame(output int ticks);
        ticks = 0;
        v_sync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (frame_tick) ticks++;
        end
        v_sync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (frame_tick) ticks++;
        end
    endtask

    int ticks;
    int tick_sum;
    bit seen;

    initial begin
        rst = 1'b1;
        {btn_right, btn_left, btn_up, btn_down} = 4'b0;
        x = '0; y = '0; blanking = 1'b1; v_sync = 1'b0;
        wait_cycles(3);
        check("reset_box_x", 32'(box_x), 32'd100);
        check("reset_box_y", 32'(box_y), 32'd100);
        check("reset_rgb", 32'({red, green, blue}), 32'd0);
        check("reset_tick", 32'(frame_tick), 32'd0);
        rst = 1'b0;
        step();

        // Pixel path and box edges
        pixel("pix_center", 150, 150, 1'b0);
        pixel("pix_x99", 99, 150, 1'b0);
        pixel("pix_x100", 100, 150, 1'b0);
        pixel("pix_x199", 199, 150, 1'b0);
        pixel("pix_x200", 200, 150, 1'b0);
        pixel("pix_y99", 150, 99, 1'b0);
        pixel("pix_y199", 150, 199, 1'b0);
        pixel("pix_y200", 150, 200, 1'b0);
        pixel("pix_blank_in", 150, 150, 1'b1);

        // Short glitch must not survive debounce
        btn_right = 1'b1;
        wait_cycles(6);
        btn_right = 1'b0;
        wait_cycles(30);
        tick_sum = 0;
        for (int f = 0; f < 3; f++) begin
            frame(ticks);
            tick_sum += ticks;
        end
        check("glitch_ticks", 32'(tick_sum), 32'd3);
        check("glitch_box_x", 32'(box_x), 32'(mx));

        // Held button: one step per frame
        btn_right = 1'b1;
        wait_cycles(30);
        for (int f = 0; f < 3; f++) begin
            frame(ticks);
            check("hold_one_tick", 32'(ticks), 32'd1);
            mx += 1;
            check("hold_box_x", 32'(box_x), 32'(mx));
        end
        btn_right = 1'b0;
        wait_cycles(30);
        pixel("moved_x102", 102, 150, 1'b0);
        pixel("moved_x103", 103, 150, 1'b0);
        pixel("moved_x203", 203, 150, 1'b0);

        // Priority: right beats up
        btn_right = 1'b1;
        btn_up = 1'b1;
        wait_cycles(30);
        frame(ticks);
        mx += 1;
        check("prio_box_x", 32'(box_x), 32'(mx));
        check("prio_box_y", 32'(box_y), 32'(my));
        btn_right = 1'b0;
        btn_up = 1'b0;
        wait_cycles(30);

        // Left saturation
        btn_left = 1'b1;
        wait_cycles(30);
        for (int f = 0; f < 150; f++) begin
            frame(ticks);
            mx = (mx > 0) ? mx - 1 : 0;
        end
        check("sat_left_box_x", 32'(box_x), 32'(mx));
        check("sat_left_zero", 32'(box_x), 32'd0);
        btn_left = 1'b0;
        wait_cycles(30);

        // Down saturation
        btn_down = 1'b1;
        wait_cycles(30);
        for (int f = 0; f < 500; f++) begin
            frame(ticks);
            my = (my < 380) ? my + 1 : 380;
        end
        check("sat_down_box_y", 32'(box_y), 32'(my));
        check("sat_down_380", 32'(box_y), 32'd380);
        check("sat_down_box_x", 32'(box_x), 32'd0);
        btn_down = 1'b0;
        wait_cycles(30);
        pixel("corner_in", 0, 380, 1'b0);
        pixel("corner_above", 0, 379, 1'b0);
        pixel("corner_far", 99, 479, 1'b0);
        pixel("corner_right", 100, 479, 1'b0);

        // Reset while a move is being applied
        btn_right = 1'b1;
        wait_cycles(30);
        pixel("pre_rst_pix", 0, 400, 1'b0);
        v_sync = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (frame_tick) seen = 1'b1;
        end
        check("rst_tick_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_box_x", 32'(box_x), 32'd100);
        check("rst_mid_box_y", 32'(box_y), 32'd100);
        check("rst_mid_rgb", 32'({red, green, blue}), 32'd0);
        check("rst_mid_tick", 32'(frame_tick), 32'd0);
        mx = 100;
        my = 100;
        btn_right = 1'b0;
        v_sync = 1'b0;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(3);
        check("post_rst_box_x", 32'(box_x), 32'd100);
        pixel("post_rst_pix", 100, 100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
